// File: rtl/ad_ram_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : ad_ram_writer_if
// Description : FIFO read port and RAM write port bundle used by ad_ram_writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ad_ram_writer_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 20,
    parameter int USEDW_W = 8
) ();
    logic [DATA_W-1:0]  fifo_q;
    logic [USEDW_W-1:0] fifo_rdusedw;
    logic               fifo_full;
    logic               fifo_rdreq;
    logic               ram_wr_en;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_wdata;
    logic               ram_ready;

    modport master (
        input  fifo_q, fifo_rdusedw, fifo_full, ram_ready,
        output fifo_rdreq, ram_wr_en, ram_addr, ram_wdata
    );

    modport slave (
        output fifo_q, fifo_rdusedw, fifo_full, ram_ready,
        input  fifo_rdreq, ram_wr_en, ram_addr, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/ad_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : ad_ram_writer
// Description : Drains the AD sample FIFO in bursts into sequential RAM words,
//               one-shot or ring-buffer capture, with count/done/overflow status.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_ram_writer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 20,
    parameter int USEDW_W   = 8,
    parameter int BURST_LEN = 8,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic              stop,
    input  wire logic              ring_mode,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [ADDR_W-1:0]      word_cnt,
    ad_ram_writer_if.master        bus
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_wait  = 3'd1;
    localparam logic [2:0] c_st_fetch = 3'd2;
    localparam logic [2:0] c_st_latch = 3'd3;
    localparam logic [2:0] c_st_write = 3'd4;

    localparam logic [ADDR_W-1:0]  c_base  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0]  c_last  = ADDR_W'(BASE_ADDR + DEPTH - 1);
    localparam logic [ADDR_W-1:0]  c_depth = ADDR_W'(DEPTH);
    localparam logic [USEDW_W-1:0] c_burst = USEDW_W'(BURST_LEN);

    logic [2:0]         r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;
    logic               r_rdreq;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [ADDR_W-1:0]  r_word_cnt;
    logic [USEDW_W-1:0] r_burst_cnt;
    logic               r_ring;
    logic               r_stop_pend;

    logic               w_accept;
    logic               w_stop_any;
    logic               w_last_word;
    logic [ADDR_W-1:0]  w_cnt_inc;
    logic [ADDR_W-1:0]  w_addr_next;
    logic [USEDW_W-1:0] w_burst_inc;

    assign w_accept    = r_wr_en && bus.ram_ready;
    assign w_stop_any  = stop || r_stop_pend;
    assign w_cnt_inc   = (r_word_cnt == '1) ? r_word_cnt : r_word_cnt + 1'b1;
    assign w_last_word = !r_ring && (w_cnt_inc == c_depth);
    assign w_addr_next = (r_ring && (r_addr == c_last)) ? c_base : r_addr + 1'b1;
    assign w_burst_inc = r_burst_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_rdreq     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_addr      <= c_base;
            r_wdata     <= '0;
            r_word_cnt  <= '0;
            r_burst_cnt <= '0;
            r_ring      <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            if (r_busy && bus.fifo_full)
                r_overflow <= 1'b1;
            // Remember a stop pulse so it takes effect at the next word boundary
            if (r_busy && stop)
                r_stop_pend <= 1'b1;

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state     <= c_st_wait;
                        r_busy      <= 1'b1;
                        r_addr      <= c_base;
                        r_word_cnt  <= '0;
                        r_burst_cnt <= '0;
                        r_done      <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_ring      <= ring_mode;
                        r_stop_pend <= stop;
                    end
                end
                c_st_wait: begin
                    if (w_stop_any) begin
                        r_state     <= c_st_idle;
                        r_busy      <= 1'b0;
                        r_stop_pend <= 1'b0;
                    end else if (bus.fifo_rdusedw >= c_burst) begin
                        r_state <= c_st_fetch;
                        r_rdreq <= 1'b1;
                    end
                end
                c_st_fetch: begin
                    r_state <= c_st_latch;
                    r_rdreq <= 1'b0;
                end
                c_st_latch: begin
                    r_state <= c_st_write;
                    r_wdata <= bus.fifo_q;
                    r_wr_en <= 1'b1;
                end
                c_st_write: begin
                    if (w_accept) begin
                        r_wr_en     <= 1'b0;
                        r_word_cnt  <= w_cnt_inc;
                        r_addr      <= w_addr_next;
                        r_stop_pend <= 1'b0;
                        if (w_last_word) begin
                            r_done      <= 1'b1;
                            r_state     <= c_st_idle;
                            r_busy      <= 1'b0;
                            r_burst_cnt <= '0;
                        end else if (w_stop_any) begin
                            r_state     <= c_st_idle;
                            r_busy      <= 1'b0;
                            r_burst_cnt <= '0;
                        end else if (w_burst_inc == c_burst) begin
                            r_state     <= c_st_wait;
                            r_burst_cnt <= '0;
                        end else begin
                            r_state     <= c_st_fetch;
                            r_burst_cnt <= w_burst_inc;
                            r_rdreq     <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                    r_rdreq <= 1'b0;
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_rdreq = r_rdreq;
    assign bus.ram_wr_en  = r_wr_en;
    assign bus.ram_addr   = r_addr;
    assign bus.ram_wdata  = r_wdata;
    assign busy           = r_busy;
    assign done           = r_done;
    assign overflow       = r_overflow;
    assign word_cnt       = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ad_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad_ram_writer
// Description : Directed self-checking bench for ad_ram_writer with FIFO/RAM models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_ram_writer;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 20;
    localparam int USEDW_W   = 8;
    localparam int BURST_LEN = 8;
    localparam int DEPTH     = 16;
    localparam int BASE_ADDR = 'h100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              ring_mode = 1'b0;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W-1:0] word_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ad_ram_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .USEDW_W(USEDW_W)) bus ();

    ad_ram_writer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .USEDW_W(USEDW_W),
        .BURST_LEN(BURST_LEN), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ring_mode(ring_mode),
        .busy(busy), .done(done), .overflow(overflow), .word_cnt(word_cnt), .bus(bus)
    );

    always #5 clk = ~clk;

    // FIFO model: word k read from the FIFO carries data value k
    int supplied = 0;
    int rd_cnt   = 0;
    assign bus.fifo_rdusedw = USEDW_W'(supplied - rd_cnt);

    always @(posedge clk) begin
        if (bus.fifo_rdreq) begin
            bus.fifo_q <= DATA_W'(rd_cnt);
            rd_cnt     <= rd_cnt + 1;
        end
    end

    logic [ADDR_W-1:0] log_addr [0:127];
    logic [DATA_W-1:0] log_data [0:127];
    int wr_count = 0;

    always @(posedge clk) begin
        if (bus.ram_wr_en && bus.ram_ready) begin
            if (wr_count < 128) begin
                log_addr[wr_count] <= bus.ram_addr;
                log_data[wr_count] <= bus.ram_wdata;
            end
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic ring);
        @(negedge clk);
        start     = 1'b1;
        ring_mode = ring;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        logic [ADDR_W-1:0] a_hold;
        logic [DATA_W-1:0] d_hold;
        int rc;

        bus.fifo_full = 1'b0;
        bus.ram_ready = 1'b1;
        rst_n    = 1'b0;
        start    = 1'b1;
        supplied = 16;
        repeat (4) @(negedge clk);
        check("rst rdreq",    bus.fifo_rdreq, 0);
        check("rst wr_en",    bus.ram_wr_en, 0);
        check("rst addr",     bus.ram_addr, BASE_ADDR);
        check("rst wdata",    bus.ram_wdata, 0);
        check("rst busy",     busy, 0);
        check("rst done",     done, 0);
        check("rst overflow", overflow, 0);
        check("rst word_cnt", word_cnt, 0);
        check("rst reads",    rd_cnt, 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("post-rst idle", busy, 0);

        // One-shot: 16 words into 0x100..0x10F
        pulse_start(1'b0);
        check("os busy T+1", busy, 1);
        check("os no rdreq in WAIT", bus.fifo_rdreq, 0);
        @(negedge clk);
        check("os rdreq T+2", bus.fifo_rdreq, 1);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        // 16 words x 3 cycles plus one WAIT cycle between the two bursts
        check("os busy span", n, 49);
        check("os done",      done, 1);
        check("os word_cnt",  word_cnt, 16);
        check("os writes",    wr_count, 16);
        check("os reads",     rd_cnt, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("os addr[%0d]", i), log_addr[i], BASE_ADDR + i);
            check($sformatf("os data[%0d]", i), log_data[i], i);
        end

        // Threshold: 7 words available is not enough for a burst
        supplied = 23;
        pulse_start(1'b0);
        check("th done cleared", done, 0);
        repeat (10) @(negedge clk);
        check("th no read at 7", rd_cnt, 16);
        check("th rdreq low at 7", bus.fifo_rdreq, 0);
        supplied = 24;
        @(negedge clk);
        check("th rdreq one cycle later", bus.fifo_rdreq, 1);
        repeat (40) @(negedge clk);
        check("th reads",    rd_cnt, 24);
        check("th writes",   wr_count, 24);
        check("th in WAIT",  busy, 1);
        check("th word_cnt", word_cnt, 8);
        check("th last addr", log_addr[23], BASE_ADDR + 7);
        check("th last data", log_data[23], 23);
        pulse_stop();
        check("th stop idle", busy, 0);
        check("th no done",   done, 0);

        // Backpressure with an overflow pulse, then stop during LATCH
        bus.ram_ready = 1'b0;
        supplied = 32;
        pulse_start(1'b0);
        n = 0;
        while (!bus.ram_wr_en && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("bp wr_en", bus.ram_wr_en, 1);
        a_hold = bus.ram_addr;
        d_hold = bus.ram_wdata;
        rc  = rd_cnt;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            bus.fifo_full = (i == 1);
            @(negedge clk);
            if (bus.ram_addr !== a_hold || bus.ram_wdata !== d_hold || bus.ram_wr_en !== 1'b1)
                bad++;
        end
        bus.fifo_full = 1'b0;
        check("bp stable",   bad, 0);
        check("bp no reads", rd_cnt, rc);
        check("bp addr",     a_hold, BASE_ADDR);
        check("bp data",     d_hold, 24);
        check("ovf set",     overflow, 1);
        bus.ram_ready = 1'b1;
        @(negedge clk);
        check("bp accepted",  wr_count, 25);
        check("bp log addr",  log_addr[24], BASE_ADDR);
        check("bp log data",  log_data[24], 24);
        check("bp next read", bus.fifo_rdreq, 1);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop word still written", bus.ram_wr_en, 1);
        @(negedge clk);
        check("stop idle",     busy, 0);
        check("stop writes",   wr_count, 26);
        check("stop addr",     log_addr[25], BASE_ADDR + 1);
        check("stop data",     log_data[25], 25);
        check("stop word_cnt", word_cnt, 2);
        check("ovf sticky",    overflow, 1);

        // Ring mode: 40 words wrap around the 16-word ring
        supplied = 66;
        pulse_start(1'b1);
        check("ring ovf cleared", overflow, 0);
        n = 0;
        while (wr_count < 66 && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("ring all written", wr_count, 66);
        repeat (5) @(negedge clk);
        check("ring word_cnt", word_cnt, 40);
        check("ring no done",  done, 0);
        check("ring busy",     busy, 1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (log_addr[26 + i] !== ADDR_W'(BASE_ADDR + (i % 16)) || log_data[26 + i] !== DATA_W'(26 + i))
                bad++;
        end
        check("ring map errors", bad, 0);
        check("ring addr pre-wrap",  log_addr[41], BASE_ADDR + 15);
        check("ring addr post-wrap", log_addr[42], BASE_ADDR);
        pulse_stop();
        check("ring stop idle", busy, 0);
        check("ring done after stop", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
